// File: rtl/cmd_reply_tx.sv
// cmd_reply_tx
//   Transmit-side companion to the UART command decoders. Received command
//   bytes are queued in a small FIFO. For each queued byte a short ASCII reply
//   is sent to the UART transmitter, one byte at a time, using a start/busy
//   handshake. The reply reports the analog power state.
//
//   Reply map (S = power_state_i sampled when the command is popped):
//     'P' / 'p' -> 'K', S      '?' -> 'S', S      anything else -> 'E'
//
//   Build option: define REPLY_CRLF_EN to append CR, LF to every reply
//   (max reply length 4 instead of 2).
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   cmd_strobe_i   1-cycle pulse, cmd_i holds a received byte
//   cmd_i          received command byte
//   power_state_i  current analog power enable level
//   tx_busy_i      UART transmitter busy
//   tx_start_o     1-cycle pulse, UART loads tx_data_o
//   tx_data_o      byte to transmit, held after the pulse
//   pending_o      queue non-empty or reply in flight (registered)
//   overflow_o     sticky: a strobe was dropped on a full queue

module cmd_reply_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_strobe_i,
  input  logic [7:0] cmd_i,
  input  logic       power_state_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       pending_o,
  output logic       overflow_o
);

  typedef enum logic [1:0] {StIdle, StWait, StSend, StGuard} state_e;

  localparam logic [FIFO_AW:0] CntFull = (FIFO_AW + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------------
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               overflow_q;
  logic               full, deq, enq;
  logic [7:0]         head;

  state_e             state_q;

  assign full = (count_q == CntFull);
  // The pop happens on the IDLE->WAIT transition, i.e. in the first cycle the
  // FSM sees the queue non-empty. This keeps strobe-to-TxStart latency at 3.
  assign deq  = (state_q == StIdle) && (count_q != '0);
  // A same-cycle dequeue frees a slot, so a strobe at full is still accepted.
  assign enq  = cmd_strobe_i && (!full || deq);
  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (enq) begin
        mem_q[wr_ptr_q] <= cmd_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + (FIFO_AW + 1)'(enq) - (FIFO_AW + 1)'(deq);
      if (cmd_strobe_i && !enq) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reply builder for the byte at the queue head
  // ---------------------------------------------------------------------------
  logic [3:0][7:0] rep_bytes;
  logic [2:0]      rep_len;
  logic [7:0]      status;

  always_comb begin
    status    = power_state_i ? 8'h31 : 8'h30;
    rep_bytes = '0;
    rep_len   = 3'd1;
    case (head)
      8'h50, 8'h70: begin
        rep_bytes[0] = 8'h4B;
        rep_bytes[1] = status;
        rep_len      = 3'd2;
      end
      8'h3F: begin
        rep_bytes[0] = 8'h53;
        rep_bytes[1] = status;
        rep_len      = 3'd2;
      end
      default: begin
        rep_bytes[0] = 8'h45;
      end
    endcase
`ifdef REPLY_CRLF_EN
    rep_bytes[rep_len[1:0]]         = 8'h0D;
    rep_bytes[rep_len[1:0] + 2'd1]  = 8'h0A;
    rep_len                         = rep_len + 3'd2;
`endif
  end

  // ---------------------------------------------------------------------------
  // Reply FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic [3:0][7:0] reply_q;
  logic [2:0]      len_q;
  logic [2:0]      idx_q;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic            pending_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      reply_q    <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      pending_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      pending_q  <= (count_q != '0) || (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            // power_state_i is captured here for the whole reply.
            reply_q <= rep_bytes;
            len_q   <= rep_len;
            idx_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (!tx_busy_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= reply_q[idx_q[1:0]];
            state_q    <= StSend;
          end
        end
        StSend: begin
          state_q <= StGuard;
        end
        StGuard: begin
          // tx_busy_i is not looked at here: the UART may not have raised it yet.
          if ((idx_q + 3'd1) < len_q) begin
            idx_q   <= idx_q + 3'd1;
            state_q <= StWait;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_cmd_reply_tx.sv
// Testbench for cmd_reply_tx: table-driven reply checks, hand-written
// multi-cycle sequences (busy handshake, overflow, reset mid-reply, power
// state change mid-reply) and a randomized phase scored against a byte-level
// reply model.
module tb_cmd_reply_tx;

  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_strobe;
  logic [7:0] cmd;
  logic       power_state;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       pending;
  logic       overflow;

  always #5 clk = ~clk;

  cmd_reply_tx #(
    .FIFO_DEPTH(4),
    .FIFO_AW   (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_strobe_i (cmd_strobe),
    .cmd_i        (cmd),
    .power_state_i(power_state),
    .tx_busy_i    (tx_busy),
    .tx_start_o   (tx_start),
    .tx_data_o    (tx_data),
    .pending_o    (pending),
    .overflow_o   (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // UART model: busy for busy_hold cycles after each start, or forced high.
  int   busy_hold  = 0;
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;
  logic busy_seen  = 1'b0;
  assign tx_busy = force_busy | (busy_cnt != 0);

  logic [7:0] exp_q[$];
  int         starts[$];
  int         last_start = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    busy_seen = tx_busy;
  end

  // Monitor: every TxStart byte is scored against the expected byte stream.
  initial forever begin
    @(negedge clk);
    if (busy_cnt > 0) busy_cnt--;
    if (tx_start === 1'b1 && rst === 1'b0) begin
      check("busy_low_at_start", busy_seen, 1'b0);
      check("start_spacing_ge3", (cyc - last_start) >= 3, 1);
      last_start = cyc;
      starts.push_back(cyc);
      check("reply_byte_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("tx_data", tx_data, exp_q.pop_front());
      busy_cnt = busy_hold;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] c);
    cmd        = c;
    cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
  endtask

  task automatic push_crlf();
`ifdef REPLY_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Reply model straight from the command map.
  task automatic model_reply(input logic [7:0] c, input logic s);
    logic [7:0] sb;
    sb = s ? "1" : "0";
    if (c == "P" || c == "p") begin
      exp_q.push_back("K");
      exp_q.push_back(sb);
    end else if (c == "?") begin
      exp_q.push_back("S");
      exp_q.push_back(sb);
    end else begin
      exp_q.push_back("E");
    end
    push_crlf();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || pending !== 1'b0) && k < budget) begin
      tick();
      k++;
    end
    check(name, (exp_q.size() == 0) && (pending === 1'b0), 1);
  endtask

  task automatic wait_starts(input string name, input int target, input int budget);
    int k = 0;
    while (starts.size() < target && k < budget) begin
      tick();
      k++;
    end
    check(name, starts.size() >= target, 1);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       ps;
    logic [7:0] b0;
    logic [7:0] b1;
    int         len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n0;
    int sc;
    logic [7:0] c;
    logic [7:0] r8;

    vecs[0] = '{cmd: 8'h50, ps: 1'b1, b0: 8'h4B, b1: 8'h31, len: 2};
    vecs[1] = '{cmd: 8'h70, ps: 1'b0, b0: 8'h4B, b1: 8'h30, len: 2};
    vecs[2] = '{cmd: 8'h3F, ps: 1'b1, b0: 8'h53, b1: 8'h31, len: 2};
    vecs[3] = '{cmd: 8'h41, ps: 1'b1, b0: 8'h45, b1: 8'h00, len: 1};
    vecs[4] = '{cmd: 8'h00, ps: 1'b0, b0: 8'h45, b1: 8'h00, len: 1};
    vecs[5] = '{cmd: 8'h51, ps: 1'b1, b0: 8'h45, b1: 8'h00, len: 1};

    rst = 1'b1; cmd_strobe = 1'b0; cmd = 8'h00; power_state = 1'b0;
    tick(2);
    check("reset_tx_start", tx_start, 1'b0);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_pending", pending, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    rst = 1'b0;
    tick(2);

    // Table: reply contents and first-byte latency with TxBusy low.
    busy_hold = 0;
    for (int i = 0; i < 6; i++) begin
      power_state = vecs[i].ps;
      n0 = starts.size();
      sc = cyc;
      exp_q.push_back(vecs[i].b0);
      if (vecs[i].len == 2) exp_q.push_back(vecs[i].b1);
      push_crlf();
      strobe(vecs[i].cmd);
      wait_drain("table_drain", 100);
      if (starts.size() > n0) check("table_first_latency", starts[n0] - sc, 3);
      else check("table_first_start_seen", starts.size(), n0 + 1);
      tick(2);
    end

    // Slow UART: second byte waits for busy to drop.
    busy_hold = 20;
    power_state = 1'b0;
    n0 = starts.size();
    model_reply(8'h3F, 1'b0);
    strobe(8'h3F);
    tick(2);
    check("pending_during_reply", pending, 1'b1);
    wait_drain("slow_drain", 300);
    if (starts.size() >= n0 + 2) check("second_after_busy", (starts[n0+1] - starts[n0]) > 20, 1);
    else check("slow_two_starts", starts.size(), n0 + 2);
    tick(3);

    // Power state toggled between the two bytes keeps the POP-cycle value.
    power_state = 1'b1;
    n0 = starts.size();
    model_reply(8'h50, 1'b1);
    strobe(8'h50);
    wait_starts("ps_first_byte", n0 + 1, 50);
    power_state = 1'b0;
    wait_drain("ps_drain", 300);
    tick(3);

    // Overflow: first command goes in flight, four more fill the queue,
    // the sixth is dropped.
    busy_hold = 2;
    force_busy = 1'b1;
    power_state = 1'b1;
    n0 = starts.size();
    model_reply(8'h50, 1'b1);
    model_reply(8'h3F, 1'b1);
    model_reply(8'h41, 1'b1);
    model_reply(8'h70, 1'b1);
    model_reply(8'h33, 1'b1);
    strobe(8'h50); strobe(8'h3F); strobe(8'h41); strobe(8'h70); strobe(8'h33);
    check("overflow_before_full", overflow, 1'b0);
    strobe(8'h21);
    tick();
    check("overflow_set", overflow, 1'b1);
    check("pending_while_blocked", pending, 1'b1);
    tick(5);
    check("no_start_while_busy", starts.size(), n0);
    force_busy = 1'b0;
    wait_drain("overflow_drain", 600);
    check("overflow_sticky", overflow, 1'b1);
    tick(3);

    // Reset in the middle of a two-byte reply.
    busy_hold = 0;
    power_state = 1'b1;
    n0 = starts.size();
    model_reply(8'h50, 1'b1);
    strobe(8'h50);
    wait_starts("rst_first_byte", n0 + 1, 50);
    rst = 1'b1;
    #1;
    check("rst_mid_tx_start", tx_start, 1'b0);
    check("rst_mid_pending", pending, 1'b0);
    check("rst_mid_overflow", overflow, 1'b0);
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick(30);
    check("no_bytes_after_reset", starts.size(), n0 + 1);
    check("pending_after_reset", pending, 1'b0);

    // Randomized phases; the queue is never allowed to overflow here.
    for (int ph = 0; ph < 3; ph++) begin
      power_state = 1'($urandom_range(0, 1));
      for (int k = 0; k < 250; k++) begin
        busy_hold = $urandom_range(0, 5);
        if (exp_q.size() < Depth && $urandom_range(0, 2) == 0) begin
          r8 = 8'($urandom);
          case ($urandom_range(0, 3))
            0: c = 8'h50;
            1: c = 8'h70;
            2: c = 8'h3F;
            default: c = r8;
          endcase
          model_reply(c, power_state);
          strobe(c);
        end else begin
          tick();
        end
      end
      wait_drain("random_drain", 300);
    end
    check("random_no_overflow", overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
